alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Decode/issue stage in front of the calculator ALU, with an 8x8 register file and result writeback.
// Optional: define DIV_ZERO_TRAP_EN to trap DIV/MOD with a zero second operand instead of issuing it.
module alu_issue_ctrl #(
    parameter int          ALU_LAT   = 1,
    parameter logic [7:0]  RESET_ACC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [7:0]  alu_c,
    output logic [5:0]  alu_opcode,
    input  logic [15:0] alu_result,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c_f,
    input  logic        alu_o,
    output logic [7:0]  acc_out,
    output logic [7:0]  acc_hi_out,
    output logic [3:0]  flags_out,
    output logic        done,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t      r_state;
    logic [17:0] r_instr;
    logic [7:0]  r_regs [8];
    logic [7:0]  r_acc, r_acc_hi;
    logic [3:0]  r_flags, r_alu_flags;
    logic [15:0] r_res;
    logic [7:0]  r_alu_a, r_alu_b, r_alu_c;
    logic [5:0]  r_alu_op;
    logic [3:0]  r_cnt;
    logic        r_done, r_err;

    logic [5:0]  w_op;
    logic        w_i;
    logic [2:0]  w_rsel;
    logic [7:0]  w_imm, w_opb;
    logic        w_is_alu, w_no_acc, w_trap;

    assign w_op     = r_instr[17:12];
    assign w_i      = r_instr[11];
    assign w_rsel   = r_instr[10:8];
    assign w_imm    = r_instr[7:0];
    assign w_opb    = w_i ? w_imm : r_acc;
    assign w_is_alu = (w_op >= 6'h09) && (w_op <= 6'h21);
    // CMP and TST only report flags
    assign w_no_acc = (w_op == 6'h17) || (w_op == 6'h18);
`ifdef DIV_ZERO_TRAP_EN
    // acc is untouched between DECODE and WB of a trapped op, so this stays stable
    assign w_trap   = ((w_op == 6'h11) || (w_op == 6'h12)) && (w_opb == 8'h00);
`else
    assign w_trap   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_instr     <= '0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
            r_acc       <= RESET_ACC;
            r_acc_hi    <= RESET_ACC;
            r_flags     <= '0;
            r_alu_flags <= '0;
            r_res       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_c     <= '0;
            r_alu_op    <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_instr <= instr;
                        r_err   <= 1'b0;
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_alu_a <= r_regs[w_rsel];
                    r_alu_b <= w_opb;
                    r_alu_c <= r_acc;
                    r_cnt   <= 4'(ALU_LAT - 1);
                    if (w_is_alu && !w_trap) begin
                        r_alu_op <= w_op;
                        r_state  <= EXEC;
                    end else begin
                        r_state  <= WB;
                    end
                end
                EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_res       <= alu_result;
                        r_alu_flags <= {alu_z, alu_n, alu_c_f, alu_o};
                        r_alu_op    <= '0;
                        r_state     <= WB;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WB: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                    if (w_is_alu) begin
                        if (w_trap) begin
                            r_err <= 1'b1;
                        end else begin
                            r_flags <= r_alu_flags;
                            if (!w_no_acc) begin
                                r_acc    <= r_res[7:0];
                                r_acc_hi <= r_res[15:8];
                            end
                        end
                    end else begin
                        case (w_op)
                            6'h00:   ;
                            6'h01:   r_regs[w_rsel] <= w_imm;
                            6'h02:   r_regs[w_rsel] <= r_acc;
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign busy       = ~in_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_c      = r_alu_c;
    assign alu_opcode = r_alu_op;
    assign acc_out    = r_acc;
    assign acc_hi_out = r_acc_hi;
    assign flags_out  = r_flags;
    assign done       = r_done;
    assign err        = r_err;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomised bench for alu_issue_ctrl: the bench plays the ALU and tracks architectural state in a model.
module tb_alu_issue_ctrl;
    localparam int         LAT     = 3;
    localparam logic [7:0] RST_ACC = 8'h3C;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] instr;
    logic [7:0]  alu_a, alu_b, alu_c;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        alu_z, alu_n, alu_c_f, alu_o;
    logic [7:0]  acc_out, acc_hi_out;
    logic [3:0]  flags_out;
    logic        done, busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mreg [8];
    logic [7:0] macc, mhi;
    logic [3:0] mflags;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.ALU_LAT(LAT), .RESET_ACC(RST_ACC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .alu_c_f(alu_c_f), .alu_o(alu_o),
        .acc_out(acc_out), .acc_hi_out(acc_hi_out), .flags_out(flags_out),
        .done(done), .busy(busy), .err(err)
    );

    function automatic logic [15:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
        logic [15:0] wa, wb;
        logic [7:0]  lo;
        wa = {8'h00, a};
        wb = {8'h00, b};
        lo = a + b + {2'b00, op};
        case (op)
            6'h09:   return wa + wb;
            6'h0A:   return wa - wb;
            6'h0D:   return wa * wb;
            6'h11:   return (b == 8'h00) ? 16'hFFFF : wa / wb;
            6'h12:   return (b == 8'h00) ? wa : wa % wb;
            6'h17:   return wa - wb;
            6'h18:   return wa & wb;
            default: return {a ^ c, lo};
        endcase
    endfunction

    function automatic logic [3:0] flg(input logic [15:0] r);
        return {r[7:0] == 8'h00, r[7], r[8], ^r};
    endfunction

    // Bench-side ALU; garbage outside EXEC so a mistimed capture shows up.
    always_comb begin
        alu_result = (alu_opcode == 6'h00) ? 16'hDEAD : alu_f(alu_opcode, alu_a, alu_b, alu_c);
        {alu_z, alu_n, alu_c_f, alu_o} = flg(alu_result);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        macc   = RST_ACC;
        mhi    = RST_ACC;
        mflags = 4'h0;
    endtask

    // Issue one instruction (called at a negedge with the block idle) and check its retirement.
    task automatic run(input logic [17:0] ins);
        logic [5:0]  op;
        logic [2:0]  rs;
        logic [7:0]  imm, ea, eb, ec;
        logic [15:0] r;
        logic        isalu, trap, eerr, seen;
        int          elat, eopc, lat, opc;
        op = ins[17:12]; rs = ins[10:8]; imm = ins[7:0];
        ea = mreg[rs]; eb = ins[11] ? imm : macc; ec = macc;
        isalu = (op >= 6'h09) && (op <= 6'h21);
        trap  = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
        trap  = isalu && (op == 6'h11 || op == 6'h12) && (eb == 8'h00);
`endif
        eerr = 1'b0;
        elat = (isalu && !trap) ? 2 + LAT : 2;
        eopc = (isalu && !trap) ? LAT : 0;
        if (isalu && !trap) begin
            r = alu_f(op, ea, eb, ec);
            mflags = flg(r);
            if (op != 6'h17 && op != 6'h18) begin
                macc = r[7:0];
                mhi  = r[15:8];
            end
        end else if (trap) eerr = 1'b1;
        else if (op == 6'h01) mreg[rs] = imm;
        else if (op == 6'h02) mreg[rs] = macc;
        else if (op != 6'h00) eerr = 1'b1;

        chk("ready", in_ready, 1'b1);
        in_valid = 1'b1;
        instr    = ins;
        @(posedge clk);
        #1;
        in_valid = 1'($urandom_range(0, 1));
        instr    = 18'($urandom);
        lat = 0; opc = 0; seen = 1'b0;
        while (lat < 40 && !seen) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                chk("dec_a", alu_a, ea);
                chk("dec_b", alu_b, eb);
                chk("dec_c", alu_c, ec);
            end
            if (alu_opcode != 6'h00) begin
                opc++;
                chk("opcode", alu_opcode, op);
            end
            if (done) seen = 1'b1;
            else begin
                in_valid = 1'($urandom_range(0, 1));
                instr    = 18'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("done_seen", done, 1'b1);
        chk("latency", lat, elat);
        chk("exec_cycles", opc, eopc);
        chk("acc", acc_out, macc);
        chk("acc_hi", acc_hi_out, mhi);
        chk("flags", flags_out, mflags);
        chk("err", err, eerr);
        chk("busy", busy, 1'b0);
    endtask

    function automatic logic [17:0] mk(input logic [5:0] op, input logic i, input logic [2:0] rs,
                                       input logic [7:0] imm);
        return {op, i, rs, imm};
    endfunction

    initial begin
        logic [5:0] op;
        int         cat;
        logic [5:0] alu_ops [6];
        alu_ops = '{6'h09, 6'h0A, 6'h0D, 6'h11, 6'h12, 6'h17};
        rst = 1'b1; in_valid = 1'b0; instr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_acc", acc_out, RST_ACC);
        chk("rst_hi", acc_hi_out, RST_ACC);
        chk("rst_flags", flags_out, 4'h0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_opc", alu_opcode, 6'h00);
        rst = 1'b0;
        @(negedge clk);

        run(mk(6'h01, 1'b1, 3'd3, 8'd5));
        run(mk(6'h09, 1'b1, 3'd3, 8'd7));
        chk("add_acc", acc_out, 8'h0C);
        chk("add_flags", flags_out, 4'b0000);

        run(mk(6'h01, 1'b1, 3'd2, 8'd0));
        run(mk(6'h09, 1'b1, 3'd2, 8'd5));
        run(mk(6'h01, 1'b1, 3'd1, 8'd5));
        run(mk(6'h17, 1'b0, 3'd1, 8'd0));
        chk("cmp_z", flags_out[3], 1'b1);
        chk("cmp_acc", acc_out, 8'h05);
        chk("cmp_b", alu_b, 8'h05);

        run(mk(6'h01, 1'b1, 3'd0, 8'd20));
        run(mk(6'h0D, 1'b1, 3'd0, 8'd20));
        chk("mul_lo", acc_out, 8'h90);
        chk("mul_hi", acc_hi_out, 8'h01);

        run(mk(6'h3F, 1'b0, 3'd0, 8'd0));
        chk("ill_err", err, 1'b1);
        run(mk(6'h00, 1'b0, 3'd0, 8'd0));
        chk("nop_clr", err, 1'b0);

        run(mk(6'h11, 1'b1, 3'd0, 8'd0));
        run(mk(6'h02, 1'b0, 3'd6, 8'd0));

        // Reset in the middle of EXEC must discard the ADD
        in_valid = 1'b1;
        instr    = mk(6'h09, 1'b1, 3'd0, 8'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_exec", alu_opcode, 6'h09);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_acc", acc_out, RST_ACC);
        chk("mid_rst_flags", flags_out, 4'h0);
        chk("mid_rst_ready", in_ready, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mid_rst_nodone", done, 1'b0);
        end

        for (int n = 0; n < 200; n++) begin
            cat = $urandom_range(0, 9);
            case (cat)
                0:       op = 6'h00;
                1, 2:    op = 6'h01;
                3:       op = 6'h02;
                4, 5, 6: op = alu_ops[$urandom_range(0, 5)];
                7:       op = 6'($urandom_range(9, 33));
                8:       op = 6'h18;
                default: op = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(3, 8)) : 6'($urandom_range(34, 63));
            endcase
            run(mk(op, 1'($urandom_range(0, 1)), 3'($urandom),
                   ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
